// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared types and constants for the serial binary-to-BCD converter.
//   state_t      : converter FSM states (IDLE -> SHIFT -> DONE -> IDLE)
//   BCD_DIGIT_W  : bits per BCD digit
//   ADD3_THRESH  : nibble value at which double-dabble adds 3 before shifting
//   BCD_NINE     : digit value used to fill the display when clamping
//   pow10()      : 10**n, evaluated at elaboration for the overflow limit
// -----------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] BCD_NINE    = 4'h9;

  // 64-bit so the limit stays exact for any digit count a display could use.
  function automatic longint unsigned pow10(input int n);
    longint unsigned acc;
    acc = 64'd1;
    for (int i = 0; i < n; i++) begin
      acc = acc * 64'd10;
    end
    return acc;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Combinational double-dabble digit corrector: adds 3 to a nibble that is 5 or
// more so the following left shift carries correctly into the next digit.
// The add wraps within 4 bits; no carry leaves the nibble.
// Ports:
//   nibble    in  4  current BCD digit
//   corrected out 4  digit after the conditional +3
// -----------------------------------------------------------------------------
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [3:0] corrected
);

  assign corrected = (nibble >= ADD3_THRESH) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/bin_to_bcd_serial.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_serial
// Sequential double-dabble converter feeding the 7-segment scan/decode stage.
// One conversion per accepted start; BIN_W shift cycles, then a one-clock done
// pulse on the same edge that updates bcd_out/ovf. Results hold until the next
// completion. Back-to-back period is BIN_W+2 clocks.
//
// Optional feature macro: BCD_CLAMP_EN
//   defined   : an overflowing value displays as all nines (9999 at default)
//   undefined : bcd_out shows value mod 10**DIGITS
//   ovf is reported in both builds.
//
// Ports:
//   clk      in   1         system clock
//   btnC     in   1         synchronous active-high reset
//   start    in   1         conversion request, honoured only in IDLE
//   bin_in   in   BIN_W     value to convert, captured on the accepting edge
//   busy     out  1         conversion in progress
//   done     out  1         one-clock completion pulse
//   bcd_out  out  4*DIGITS  packed BCD, ones digit in [3:0]
//   ovf      out  1         captured value was >= 10**DIGITS
// -----------------------------------------------------------------------------
module bin_to_bcd_serial
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          btnC,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          ovf
);

  localparam int              BCD_W     = BCD_DIGIT_W * DIGITS;
  localparam int              CNT_W     = $clog2(BIN_W + 1);
  localparam longint unsigned OVF_LIMIT = pow10(DIGITS);

  state_t           state;
  state_t           state_next;
  logic [BIN_W-1:0] sh_bin;
  logic [BCD_W-1:0] sh_bcd;
  logic [BCD_W-1:0] sh_bcd_adj;
  logic [CNT_W-1:0] cnt;
  logic             ovf_n;
  logic             accept;
  logic             ovf_in;
  logic [BCD_W-1:0] result;

  // Per-digit +3 correction ahead of each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nibble    (sh_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .corrected (sh_bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign accept = (state == IDLE) && start;
  assign ovf_in = 64'(bin_in) >= OVF_LIMIT;

`ifdef BCD_CLAMP_EN
  assign result = ovf_n ? {DIGITS{BCD_NINE}} : sh_bcd;
`else
  // The truncated register already holds value mod 10**DIGITS because carries
  // only move upward and the top carry is dropped.
  assign result = sh_bcd;
`endif

  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values and the ordering of statements cannot change behaviour.
  always_ff @(posedge clk) begin
    if (btnC) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      // cnt == 1 here means this edge performs the final shift.
      SHIFT:   if (cnt == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (btnC) begin
      sh_bin  <= '0;
      sh_bcd  <= '0;
      cnt     <= '0;
      ovf_n   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            sh_bin <= bin_in;
            sh_bcd <= '0;
            cnt    <= CNT_W'(BIN_W);
            ovf_n  <= ovf_in;
            busy   <= 1'b1;
          end
        end
        SHIFT: begin
          // The bit leaving the top digit falls off the left end of the shift.
          {sh_bcd, sh_bin} <= {sh_bcd_adj, sh_bin} << 1;
          cnt              <= cnt - 1'b1;
        end
        DONE: begin
          bcd_out <= result;
          ovf     <= ovf_n;
          done    <= 1'b1;
          busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
